pe_mac_acc: RTL and testbench

Parametrised, pipelined convolution processing element for the LeNet-5 accelerator. Each beat multiplies TAPS signed IF/weight pairs and reduces them in an adder tree. Products accumulate across a burst of beats (input channels) with a bias preload. On the last beat it emits one result through optional ReLU and rounding/saturating quantisation, with a valid strobe. It replaces the fixed 25-tap, single-channel, unhandshaked PE in the conv/FC datapath.

---
 rtl/pe_pkg.sv | 56 +++++
 rtl/pe_adder_tree.sv | 33 +++
 rtl/pe_mac_acc.sv | 150 +++++++++++++++
 tb/tb_pe_mac_acc.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared constants and helpers for the convolution PE: lane unpacking and
// round-half-up / saturating quantisation.
package pe_pkg;

    localparam int unsigned TapsDef  = 25;
    localparam int unsigned DwDef    = 8;
    localparam int unsigned AwDef    = 32;
    localparam int unsigned ShiftDef = 7;
    localparam int unsigned OutWDef  = 8;

    // Helpers work on fixed maximum widths; callers zero/sign-extend into them.
    localparam int unsigned MaxDw   = 16;
    localparam int unsigned MaxTaps = 64;
    localparam int unsigned MaxVecW = MaxDw * MaxTaps;
    localparam int unsigned MaxAw   = 64;

    function automatic logic signed [MaxDw-1:0] lane_get(
        input logic [MaxVecW-1:0] vec,
        input int unsigned        k,
        input int unsigned        dw
    );
        logic [MaxVecW-1:0]      sh;
        logic signed [MaxDw-1:0] v;
        sh = vec >> (k * dw);
        v  = sh[MaxDw-1:0];
        v  = v <<< (MaxDw - dw);
        return v >>> (MaxDw - dw);
    endfunction

    function automatic logic signed [MaxAw-1:0] round_sat(
        input logic signed [MaxAw-1:0] r,
        input int unsigned             shift,
        input int unsigned             out_w
    );
        logic signed [MaxAw-1:0] q;
        logic signed [MaxAw-1:0] rb;
        logic signed [MaxAw-1:0] hi;
        logic signed [MaxAw-1:0] lo;
        q  = r >>> shift;
        rb = r >>> (shift - 1);
        // Round half up: add the most significant discarded bit.
        if (rb[0]) begin
            q = q + 64'sd1;
        end
        hi = signed'((64'd1 << (out_w - 1)) - 64'd1);
        lo = -hi - 64'sd1;
        if (q > hi) begin
            return hi;
        end
        if (q < lo) begin
            return lo;
        end
        return q;
    endfunction

endpackage

// File: rtl/pe_adder_tree.sv
// Combinational balanced reduction of TAPS signed products into an AW-bit sum.
module pe_adder_tree
    import pe_pkg::*;
#(
    parameter int unsigned TAPS = TapsDef,
    parameter int unsigned IW   = 2 * DwDef,
    parameter int unsigned AW   = AwDef
) (
    input  logic [TAPS*IW-1:0] prod_i,
    output logic [AW-1:0]      sum_o
);

    localparam int unsigned Levels = (TAPS > 1) ? $clog2(TAPS) : 0;
    localparam int unsigned Leaves = 1 << Levels;

    always_comb begin
        logic signed [AW-1:0] node [Leaves];
        for (int k = 0; k < Leaves; k++) begin
            node[k] = '0;
        end
        for (int k = 0; k < TAPS; k++) begin
            node[k] = {{(AW-IW){prod_i[k*IW+IW-1]}}, prod_i[k*IW +: IW]};
        end
        // Pairwise in-place reduction, one halving per tree level.
        for (int w = Leaves / 2; w >= 1; w = w / 2) begin
            for (int k = 0; k < w; k++) begin
                node[k] = node[2*k] + node[2*k+1];
            end
        end
        sum_o = node[0];
    end

endmodule

// File: rtl/pe_mac_acc.sv
// Pipelined multi-channel MAC processing element: multiply, adder tree,
// bias-preloaded accumulation, then ReLU and optional quantisation.
module pe_mac_acc
    import pe_pkg::*;
#(
    parameter int unsigned TAPS  = TapsDef,
    parameter int unsigned DW    = DwDef,
    parameter int unsigned AW    = AwDef,
    parameter int unsigned SHIFT = ShiftDef,
    parameter int unsigned OUT_W = OutWDef
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_first,
    input  logic              in_last,
    input  logic [TAPS*DW-1:0] if_vec,
    input  logic [TAPS*DW-1:0] w_vec,
    input  logic [AW-1:0]     bias,
    input  logic              relu_en,
    input  logic              quan_en,
    output logic              out_valid,
    output logic [AW-1:0]     pe_out
);

    localparam int unsigned PW = 2 * DW;

    logic [TAPS*PW-1:0] prod_d, prod_q;
    logic               s1_valid_q, s1_first_q, s1_last_q, s1_relu_q, s1_quan_q;
    logic [AW-1:0]      s1_bias_q;
    logic [AW-1:0]      sum_d, sum_q;
    logic               s2_valid_q, s2_first_q, s2_last_q, s2_relu_q, s2_quan_q;
    logic [AW-1:0]      s2_bias_q;
    logic [AW-1:0]      acc_d, acc_q, acc_next;
    logic               fin_valid_q, fin_relu_q, fin_quan_q;
    logic [AW-1:0]      fin_q;
    logic               r_valid_q, r_quan_q;
    logic [AW-1:0]      r_q;
    logic [AW-1:0]      pe_out_d, pe_out_q;
    logic               out_valid_q;

    always_comb begin
        logic [MaxVecW-1:0]        if_wide;
        logic [MaxVecW-1:0]        w_wide;
        logic signed [MaxDw-1:0]   a;
        logic signed [MaxDw-1:0]   b;
        logic signed [2*MaxDw-1:0] p;
        if_wide = '0;
        w_wide  = '0;
        a       = '0;
        b       = '0;
        p       = '0;
        prod_d  = '0;
        if_wide[TAPS*DW-1:0] = if_vec;
        w_wide[TAPS*DW-1:0]  = w_vec;
        for (int unsigned k = 0; k < TAPS; k++) begin
            a = lane_get(if_wide, k, DW);
            b = lane_get(w_wide, k, DW);
            p = a * b;
            prod_d[k*PW +: PW] = p[PW-1:0];
        end
    end

    pe_adder_tree #(
        .TAPS (TAPS),
        .IW   (PW),
        .AW   (AW)
    ) u_tree (
        .prod_i (prod_q),
        .sum_o  (sum_d)
    );

    always_comb begin
        acc_next = (s2_first_q ? s2_bias_q : acc_q) + sum_q;
        acc_d    = acc_q;
        if (s2_valid_q) begin
            // The last beat hands its total to the output stage and idles acc.
            acc_d = s2_last_q ? '0 : acc_next;
        end
    end

    always_comb begin
        pe_out_d = pe_out_q;
        if (r_valid_q) begin
            pe_out_d = r_quan_q ? AW'(round_sat(MaxAw'($signed(r_q)), SHIFT, OUT_W)) : r_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_relu_q   <= 1'b0;
            s1_quan_q   <= 1'b0;
            s1_bias_q   <= '0;
            sum_q       <= '0;
            s2_valid_q  <= 1'b0;
            s2_first_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_relu_q   <= 1'b0;
            s2_quan_q   <= 1'b0;
            s2_bias_q   <= '0;
            acc_q       <= '0;
            fin_valid_q <= 1'b0;
            fin_relu_q  <= 1'b0;
            fin_quan_q  <= 1'b0;
            fin_q       <= '0;
            r_valid_q   <= 1'b0;
            r_quan_q    <= 1'b0;
            r_q         <= '0;
            out_valid_q <= 1'b0;
            pe_out_q    <= '0;
        end else begin
            prod_q      <= prod_d;
            s1_valid_q  <= in_valid;
            s1_first_q  <= in_valid & in_first;
            s1_last_q   <= in_valid & in_last;
            s1_relu_q   <= relu_en;
            s1_quan_q   <= quan_en;
            s1_bias_q   <= bias;

            sum_q       <= sum_d;
            s2_valid_q  <= s1_valid_q;
            s2_first_q  <= s1_first_q;
            s2_last_q   <= s1_last_q;
            s2_relu_q   <= s1_relu_q;
            s2_quan_q   <= s1_quan_q;
            s2_bias_q   <= s1_bias_q;

            acc_q       <= acc_d;
            fin_valid_q <= s2_valid_q & s2_last_q;
            fin_relu_q  <= s2_relu_q;
            fin_quan_q  <= s2_quan_q;
            fin_q       <= acc_next;

            r_valid_q   <= fin_valid_q;
            r_quan_q    <= fin_quan_q;
            r_q         <= (fin_relu_q && fin_q[AW-1]) ? '0 : fin_q;

            out_valid_q <= r_valid_q;
            pe_out_q    <= pe_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign pe_out    = pe_out_q;

endmodule

// File: tb/tb_pe_mac_acc.sv
// Directed bench for pe_mac_acc: hand-computed results, latency and strobe counts.
module tb_pe_mac_acc;

    localparam int TAPS  = 25;
    localparam int DW    = 8;
    localparam int AW    = 32;
    localparam int SHIFT = 7;
    localparam int OUT_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_first, in_last, relu_en, quan_en;
    logic [TAPS*DW-1:0] if_vec, w_vec;
    logic [AW-1:0]      bias;
    logic               out_valid;
    logic [AW-1:0]      pe_out;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int a;

    logic [AW-1:0] got_q[$];
    int            got_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            got_q.push_back(pe_out);
            got_cyc.push_back(cyc);
        end
    end

    pe_mac_acc #(
        .TAPS  (TAPS),
        .DW    (DW),
        .AW    (AW),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_last   (in_last),
        .if_vec    (if_vec),
        .w_vec     (w_vec),
        .bias      (bias),
        .relu_en   (relu_en),
        .quan_en   (quan_en),
        .out_valid (out_valid),
        .pe_out    (pe_out)
    );

    task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic set_all(input int x, input int y);
        for (int k = 0; k < TAPS; k++) begin
            if_vec[k*DW +: DW] = DW'(x);
            w_vec[k*DW +: DW]  = DW'(y);
        end
    endtask

    task automatic set_lane(input int k, input int x, input int y);
        if_vec[k*DW +: DW] = DW'(x);
        w_vec[k*DW +: DW]  = DW'(y);
    endtask

    task automatic clear_lanes();
        if_vec = '0;
        w_vec  = '0;
    endtask

    task automatic beat(input bit f, input bit l, input int b, input bit relu, input bit quan);
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        bias     = AW'(b);
        relu_en  = relu;
        quan_en  = quan;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    // Idle cycle with junk on the fields that must be ignored.
    task automatic bubble();
        in_valid = 1'b0;
        in_first = 1'b1;
        in_last  = 1'b1;
        bias     = AW'(12345);
        @(posedge clk);
        #1;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input string tag, input int exp, input int exp_cyc);
        logic [AW-1:0] v;
        int            c;
        if (got_q.size() == 0) begin
            check({tag, " present"}, 0, 1);
        end else begin
            v = got_q.pop_front();
            c = got_cyc.pop_front();
            check(tag, v, AW'(exp));
            check({tag, " cycle"}, AW'(c), AW'(exp_cyc));
        end
    endtask

    task automatic expect_none(input string tag);
        check({tag, " extra strobes"}, AW'(got_q.size()), 0);
        got_q.delete();
        got_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        relu_en  = 1'b0;
        quan_en  = 1'b0;
        bias     = '0;
        clear_lanes();
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", AW'(out_valid), 0);
        check("reset pe_out", pe_out, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        set_all(1, 1);
        beat(1, 1, 0, 0, 0);
        a = cyc;
        settle();
        expect_res("single ones", 25, a + 4);
        expect_none("single ones");

        set_all(-128, 127);
        beat(1, 1, 0, 0, 0);
        a = cyc;
        beat(1, 1, 0, 1, 0);
        settle();
        expect_res("extreme raw", -406400, a + 4);
        expect_res("extreme relu", 0, a + 5);
        expect_none("extreme");

        set_all(2, 3);
        beat(1, 0, 10, 0, 0);
        for (int i = 0; i < 4; i++) beat(0, 0, 777, 0, 0);
        beat(0, 1, 777, 0, 0);
        a = cyc;
        settle();
        expect_res("burst6", 910, a + 4);
        expect_none("burst6");

        beat(1, 0, 10, 0, 0);
        for (int i = 0; i < 4; i++) begin
            bubble();
            beat(0, 0, 777, 0, 0);
        end
        bubble();
        bubble();
        beat(0, 1, 777, 0, 0);
        a = cyc;
        settle();
        expect_res("burst6 bubbles", 910, a + 4);
        expect_none("burst6 bubbles");
        check("hold pe_out", pe_out, AW'(910));
        check("hold out_valid", AW'(out_valid), 0);

        clear_lanes();
        set_lane(0, 96, 2);
        beat(1, 1, 0, 0, 1);
        a = cyc;
        clear_lanes();
        set_lane(0, 127, 1);
        set_lane(1, 64, 1);
        beat(1, 1, 0, 0, 1);
        clear_lanes();
        for (int k = 0; k < 4; k++) set_lane(k, 100, 100);
        beat(1, 1, 0, 0, 1);
        clear_lanes();
        for (int k = 0; k < 4; k++) set_lane(k, -100, 100);
        beat(1, 1, 0, 0, 1);
        beat(1, 1, 0, 1, 1);
        beat(1, 1, 0, 0, 0);
        settle();
        expect_res("quant 192", 2, a + 4);
        expect_res("quant 191", 1, a + 5);
        expect_res("quant sat hi", 127, a + 6);
        expect_res("quant sat lo", -128, a + 7);
        expect_res("quant relu", 0, a + 8);
        expect_res("unquant neg", -40000, a + 9);
        expect_none("quant");

        set_all(1, 1);
        beat(1, 0, 0, 0, 0);
        beat(0, 0, 0, 0, 0);
        beat(0, 0, 0, 0, 0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_last  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst      = 1'b0;
        settle();
        expect_none("mid-burst reset");
        beat(0, 1, 0, 0, 0);
        a = cyc;
        settle();
        expect_res("after reset", 25, a + 4);
        expect_none("after reset");

        set_all(1, 1);
        beat(1, 1, 0, 0, 0);
        a = cyc;
        set_all(2, 1);
        beat(1, 1, 0, 0, 0);
        set_all(3, 1);
        beat(1, 1, 0, 0, 0);
        settle();
        expect_res("b2b 25", 25, a + 4);
        expect_res("b2b 50", 50, a + 5);
        expect_res("b2b 75", 75, a + 6);
        expect_none("b2b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
